// File: rtl/complex_pkg.sv
// Shared constants for the complex operand loader: default width, state and word-index encodings.
// Imported by the loader interface and the loader itself.
package complex_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    localparam logic [1:0] W_RA = 2'd0;
    localparam logic [1:0] W_IA = 2'd1;
    localparam logic [1:0] W_RB = 2'd2;
    localparam logic [1:0] W_IB = 2'd3;

    localparam logic OP_SUM = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_LOAD   = LOAD,
        ST_HOLD   = HOLD,
        ST_RESULT = RESULT
    } state_t;

endpackage

// File: rtl/complex_operand_loader_if.sv
// Loader bus: operand word stream in, ALU operands/result, captured result stream out.
// master = loader side, slave = environment (feeder, ALU, result consumer).
interface complex_operand_loader_if #(
    parameter int DATA_W = complex_pkg::DATA_W_DEF
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  in_op;
    logic [DATA_W-1:0]     Real_A;
    logic [DATA_W-1:0]     Im_A;
    logic [DATA_W-1:0]     Real_B;
    logic [DATA_W-1:0]     Im_B;
    logic                  sum_sub;
    logic                  alu_done;
    logic [2*DATA_W-1:0]   res_in;
    logic                  res_valid;
    logic                  res_ready;
    logic [2*DATA_W-1:0]   res_out;
    logic                  err;

    modport master (
        input  in_valid, in_data, in_op, alu_done, res_in, res_ready,
        output in_ready, Real_A, Im_A, Real_B, Im_B, sum_sub, res_valid, res_out, err
    );

    modport slave (
        output in_valid, in_data, in_op, alu_done, res_in, res_ready,
        input  in_ready, Real_A, Im_A, Real_B, Im_B, sum_sub, res_valid, res_out, err
    );
endinterface

// File: rtl/complex_operand_loader.sv
// Collects Real_A/Im_A/Real_B/Im_B + op, holds them for the ALU, captures its result ALU_LAT+1 edges
// after the last word (retrying while alu_done=0); in_ready low in HOLD/RESULT, result held until res_ready.
// LOADER_TIMEOUT_EN adds a mid-set idle watchdog that aborts the set and pulses err.
module complex_operand_loader
    import complex_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ALU_LAT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    complex_operand_loader_if.master bus
);

    localparam int CW = $clog2(ALU_LAT + 1);

    state_t              state, state_nxt;
    logic [1:0]          widx;
    logic [CW-1:0]       hold_cnt;
    logic [DATA_W-1:0]   ra, ia, rb, ib;
    logic                op;
    logic [2*DATA_W-1:0] res;
    logic                res_vld;
    logic                err_q;
    logic                in_rdy, accept, capture, abort;

    assign in_rdy  = (state == ST_IDLE) || (state == ST_LOAD);
    assign accept  = bus.in_valid && in_rdy;
    assign capture = (state == ST_HOLD) && (hold_cnt == '0) && bus.alu_done;

`ifdef LOADER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;

    assign abort = (state == ST_LOAD) && !accept && (idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= abort;
            if (state != ST_LOAD || accept || abort)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    // Without the watchdog TIMEOUT is meaningless; this term is constant false.
    assign abort = (TIMEOUT < 0);
    assign err_q = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (accept && widx == W_IB) state_nxt = ST_HOLD;
                else if (abort)             state_nxt = ST_IDLE;
            end
            ST_HOLD:   if (capture) state_nxt = ST_RESULT;
            ST_RESULT: if (bus.res_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            widx     <= W_RA;
            hold_cnt <= '0;
            ra       <= '0;
            ia       <= '0;
            rb       <= '0;
            ib       <= '0;
            op       <= OP_SUB;
            res      <= '0;
            res_vld  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                case (widx)
                    W_RA: begin
                        ra <= bus.in_data;
                        op <= bus.in_op;
                    end
                    W_IA: ia <= bus.in_data;
                    W_RB: rb <= bus.in_data;
                    W_IB: ib <= bus.in_data;
                endcase
                widx <= widx + 2'd1;
            end else if (abort) begin
                widx <= W_RA;
            end

            // Counter reaches zero exactly one edge before the earliest legal capture edge.
            if (accept && widx == W_IB)
                hold_cnt <= CW'(ALU_LAT);
            else if (state == ST_HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - CW'(1);

            if (capture) begin
                res     <= bus.res_in;
                res_vld <= 1'b1;
            end else if (state == ST_RESULT && bus.res_ready) begin
                res_vld <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.Real_A    = ra;
    assign bus.Im_A      = ia;
    assign bus.Real_B    = rb;
    assign bus.Im_B      = ib;
    assign bus.sum_sub   = op;
    assign bus.res_out   = res;
    assign bus.res_valid = res_vld;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_complex_operand_loader.sv
// Bench for complex_operand_loader: directed sets plus randomized sets checked against an arithmetic model.
module tb_complex_operand_loader;
    import complex_pkg::*;

    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int TMO = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    complex_operand_loader_if #(.DATA_W(DW)) bus();

    complex_operand_loader #(.DATA_W(DW), .ALU_LAT(LAT), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [2*DW-1:0] alu_ref(input logic [DW-1:0] ra, ia, rb, ib, input logic op);
        logic [DW-1:0] re, im;
        re = op ? ra + rb : ra - rb;
        im = op ? ia + ib : ia - ib;
        return {re, im};
    endfunction

    task automatic send_word(input logic [DW-1:0] d, input logic op);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_op    = op;
        n = 0;
        @(negedge clock);
        while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL accept_wait: in_ready=%0b required 1 within 50 cycles", bus.in_ready);
        end
        @(posedge clock); #1;
    endtask

    task automatic run_set(input string name, input logic [DW-1:0] ra, ia, rb, ib,
                           input logic op, input int extra, input int bp);
        logic [2*DW-1:0] exp;
        logic            done_now;
        exp = alu_ref(ra, ia, rb, ib, op);
        bus.alu_done = 1'b0;
        send_word(ra, op);
        send_word(ia, ~op);
        send_word(rb, ~op);
        send_word(ib, $urandom_range(0, 1));
        bus.in_valid = 1'b0;
        for (int k = 1; k <= LAT + 1 + extra; k++) begin
            done_now     = (k >= LAT + 1 + extra);
            bus.alu_done = done_now;
            bus.res_in   = done_now ? exp : ~exp;
            @(negedge clock);
            total++;
            if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s hold_k%0d: in_ready=%0b res_valid=%0b required 0 0", name, k, bus.in_ready, bus.res_valid);
            end
            @(posedge clock); #1;
        end
        bus.alu_done = 1'b0;
        bus.res_in   = {$urandom, $urandom};
        bus.res_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            @(negedge clock);
            total++;
            if (bus.res_valid !== 1'b1 || bus.res_out !== exp || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s stall%0d: valid=%0b out=%h rdy=%0b required 1 %h 0", name, i, bus.res_valid, bus.res_out, bus.in_ready, exp);
            end
            @(posedge clock); #1;
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clock);
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_out !== exp) begin
            bad++;
            $display("FAIL %s result: valid=%0b out=%h required 1 %h", name, bus.res_valid, bus.res_out, exp);
        end
        total++;
        if (bus.Real_A !== ra || bus.Im_A !== ia || bus.Real_B !== rb || bus.Im_B !== ib || bus.sum_sub !== op) begin
            bad++;
            $display("FAIL %s operands: %h %h %h %h op=%0b required %h %h %h %h op=%0b", name,
                     bus.Real_A, bus.Im_A, bus.Real_B, bus.Im_B, bus.sum_sub, ra, ia, rb, ib, op);
        end
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("FAIL %s err: err=%0b required 0", name, bus.err);
        end
        @(posedge clock); #1;
        bus.res_ready = 1'b0;
        @(negedge clock);
        total++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.Real_A !== ra || bus.Im_B !== ib) begin
            bad++;
            $display("FAIL %s release: valid=%0b rdy=%0b ra=%h ib=%h required 0 1 %h %h", name,
                     bus.res_valid, bus.in_ready, bus.Real_A, bus.Im_B, ra, ib);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if (bus.Real_A !== '0 || bus.Im_A !== '0 || bus.Real_B !== '0 || bus.Im_B !== '0 ||
            bus.sum_sub !== 1'b0 || bus.res_out !== '0 || bus.res_valid !== 1'b0 ||
            bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: ra=%h sum_sub=%0b res=%h valid=%0b err=%0b rdy=%0b required zeros rdy=1",
                     bus.Real_A, bus.sum_sub, bus.res_out, bus.res_valid, bus.err, bus.in_ready);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_sum();
        run_set("sum", 32'd3, 32'd4, 32'd1, 32'd2, OP_SUM, 0, 0);
    endtask

    task automatic test_sub();
        run_set("sub", 32'd5, 32'd7, 32'd2, 32'd9, OP_SUB, 0, 0);
    endtask

    task automatic test_wrap();
        run_set("wrap", 32'hFFFF_FFFF, 32'd10, 32'd1, 32'd20, OP_SUM, 0, 0);
    endtask

    task automatic test_backpressure();
        run_set("backpressure", $urandom, $urandom, $urandom, $urandom, OP_SUB, 2, 5);
    endtask

    task automatic test_reset_mid_load();
        logic [DW-1:0] a;
        a = $urandom | 32'd1;
        send_word(a, OP_SUM);
        send_word($urandom, OP_SUB);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (bus.Real_A !== '0 || bus.Im_A !== '0 || bus.sum_sub !== 1'b0 ||
            bus.res_out !== '0 || bus.res_valid !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_load: ra=%h ia=%h sum_sub=%0b res=%h valid=%0b required zeros",
                     bus.Real_A, bus.Im_A, bus.sum_sub, bus.res_out, bus.res_valid);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        run_set("after_reset", 32'd11, 32'd22, 32'd33, 32'd44, OP_SUM, 0, 0);
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        send_word(32'hDEAD_0001, OP_SUM);
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL timeout_ready%0d: in_ready=%0b required 1", k, bus.in_ready);
            end
            @(posedge clock); #1;
            total++;
            if (bus.err !== (k == TMO)) begin
                bad++;
                $display("FAIL timeout_err%0d: err=%0b required %0b", k, bus.err, (k == TMO));
            end
        end
        run_set("after_timeout", 32'd7, 32'd8, 32'd9, 32'd10, OP_SUB, 0, 0);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_set("random", $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_op     = 1'b0;
        bus.alu_done  = 1'b0;
        bus.res_in    = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_sum();
        test_sub();
        test_wrap();
        test_backpressure();
        test_reset_mid_load();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
